// File: rtl/cam_alloc_controller.sv
// Lookup-or-allocate tag tracker around a CAM-capable register file.
// Optional CAM_ALLOC_STATS_EN adds saturating hit/alloc/full counters.
module tri_port_regfile #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 8,
    parameter int NUM_ENTRY = 4
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 read_en_in,
    input  logic [NUM_ENTRY-1:0]                 read_entry_addr_decoded_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
    input  logic                                 write_en_in,
    input  logic [NUM_ENTRY-1:0]                 write_entry_addr_decoded_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
    input  logic                                 cam_en_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] cam_entry_in,
    output logic [NUM_ENTRY-1:0]                 cam_result_decoded_out
);
    logic [NUM_ENTRY-1:0][SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rd_mux;
    logic [NUM_ENTRY-1:0] match;

    always_comb begin
        rd_mux = '0;
        match  = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (read_entry_addr_decoded_in[i]) rd_mux = rd_mux | mem[i];
            match[i] = (mem[i] == cam_entry_in);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mem                    <= '0;
            read_entry_out         <= '0;
            cam_result_decoded_out <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                if (write_en_in && write_entry_addr_decoded_in[i]) mem[i] <= write_entry_in;
            end
            if (read_en_in) read_entry_out <= rd_mux;
            if (cam_en_in) cam_result_decoded_out <= match;
        end
    end
endmodule

module cam_alloc_controller #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 8,
    parameter int NUM_ENTRY = 4,
    localparam int IDX_W = $clog2(NUM_ENTRY)
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 req_valid_in,
    output logic                                 req_ready_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] req_key_in,
    output logic                                 resp_valid_out,
    input  logic                                 resp_ready_in,
    output logic [IDX_W-1:0]                     resp_index_out,
    output logic                                 resp_hit_out,
    output logic                                 resp_alloc_out,
    output logic                                 resp_full_out,
    input  logic                                 release_valid_in,
    input  logic [IDX_W-1:0]                     release_index_in,
`ifdef CAM_ALLOC_STATS_EN
    output logic [31:0]                          stat_hit_out,
    output logic [31:0]                          stat_alloc_out,
    output logic [31:0]                          stat_full_out,
`endif
    output logic [NUM_ENTRY-1:0]                 valid_vec_out,
    output logic [IDX_W:0]                       count_out
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOOKUP  = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0] state;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] key;
    logic [NUM_ENTRY-1:0] valid_vec, rel_dec, eff_valid;
    logic [NUM_ENTRY-1:0] cam_hits, hit_vec, wr_dec;
    logic [IDX_W-1:0] hit_idx, free_idx;
    logic any_hit, any_free, write_en;
    logic [IDX_W:0] count;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] unused_read_data;

    tri_port_regfile #(
        .SINGLE_ENTRY_SIZE_IN_BITS(SINGLE_ENTRY_SIZE_IN_BITS),
        .NUM_ENTRY(NUM_ENTRY)
    ) regfile (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .read_en_in(1'b0),
        .read_entry_addr_decoded_in('0),
        .read_entry_out(unused_read_data),
        .write_en_in(write_en),
        .write_entry_addr_decoded_in(wr_dec),
        .write_entry_in(key),
        .cam_en_in(state == LOOKUP),
        .cam_entry_in(key),
        .cam_result_decoded_out(cam_hits)
    );

    // Entries being released this cycle are treated as already free.
    always_comb begin
        rel_dec = '0;
        if (release_valid_in) rel_dec[release_index_in] = 1'b1;
        eff_valid = valid_vec & ~rel_dec;
        hit_vec   = cam_hits & eff_valid;
        any_hit   = |hit_vec;
        any_free  = ~&eff_valid;
        hit_idx   = '0;
        free_idx  = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = IDX_W'(i);
            if (!eff_valid[i]) free_idx = IDX_W'(i);
        end
        write_en = (state == RESOLVE) && !any_hit && any_free;
        wr_dec = '0;
        if (write_en) wr_dec[free_idx] = 1'b1;
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_ENTRY; i++) count = count + (IDX_W+1)'(valid_vec[i]);
    end

    // OR-ing the allocation after the release mask lets allocation win.
    always_ff @(posedge clk_in) begin
        if (reset_in) valid_vec <= '0;
        else          valid_vec <= eff_valid | wr_dec;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state          <= IDLE;
            key            <= '0;
            resp_index_out <= '0;
            resp_hit_out   <= 1'b0;
            resp_alloc_out <= 1'b0;
            resp_full_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_in) begin
                        key   <= req_key_in;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: state <= RESOLVE;
                RESOLVE: begin
                    resp_hit_out   <= any_hit;
                    resp_alloc_out <= !any_hit && any_free;
                    resp_full_out  <= !any_hit && !any_free;
                    resp_index_out <= any_hit ? hit_idx : (any_free ? free_idx : '0);
                    state          <= RESP;
                end
                RESP: if (resp_ready_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAM_ALLOC_STATS_EN
    logic accept;
    assign accept = (state == RESP) && resp_ready_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            stat_hit_out   <= '0;
            stat_alloc_out <= '0;
            stat_full_out  <= '0;
        end else if (accept) begin
            if (resp_hit_out && stat_hit_out != '1) stat_hit_out <= stat_hit_out + 32'd1;
            if (resp_alloc_out && stat_alloc_out != '1) stat_alloc_out <= stat_alloc_out + 32'd1;
            if (resp_full_out && stat_full_out != '1) stat_full_out <= stat_full_out + 32'd1;
        end
    end
`endif

    assign req_ready_out  = (state == IDLE);
    assign resp_valid_out = (state == RESP);
    assign valid_vec_out  = valid_vec;
    assign count_out      = count;
endmodule
